imuldiv_div_client: RTL and testbench

Initiator-side front end for the iterative divider: accepts a 4-way divide/remainder command with a tag from the execute stage. It then drives the divider's request channel (`divreq_*`) and consumes its response channel (`divresp_*`). It returns the selected 32-bit half with the tag over a val/rdy result port, and reports the round-trip latency of the last transaction. One transaction is in flight at a time.

---
 rtl/imuldiv_div_client.sv | 136 +++++++++++++
 tb/tb_imuldiv_div_client.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imuldiv_div_client.sv
// imuldiv_div_client: execute-stage front end that issues one divide/remainder at a time to the iterative divider.
// Optional feature: define IMULDIV_DIV_CLIENT_ZERO_BYPASS_EN to answer b==0 commands locally without the divider.
`ifndef IMULDIV_DIVREQ_MSG_FUNC_SIGNED
`define IMULDIV_DIVREQ_MSG_FUNC_SIGNED 1'd0
`endif
`ifndef IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED
`define IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED 1'd1
`endif

module imuldiv_div_client #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_val,
    output logic             cmd_rdy,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             divreq_msg_fn,
    output logic [31:0]      divreq_msg_a,
    output logic [31:0]      divreq_msg_b,
    output logic             divreq_val,
    input  logic             divreq_rdy,
    input  logic [63:0]      divresp_msg_result,
    input  logic             divresp_val,
    output logic             divresp_rdy,
    output logic             res_val,
    input  logic             res_rdy,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic [7:0]       lat_cycles
);

    // IDLE: accept command | REQ: offer operands | WAIT: await divider | RESP: hold result
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      res_q, res_d;
    logic [7:0]       lat_cnt_q, lat_cnt_d;
    logic [7:0]       lat_q, lat_d;
    logic [7:0]       lat_cnt_inc;

    assign lat_cnt_inc = (lat_cnt_q == 8'hFF) ? 8'hFF : lat_cnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        res_d     = res_q;
        lat_cnt_d = lat_cnt_q;
        lat_d     = lat_q;
        case (state_q)
            IDLE: begin
                if (cmd_val) begin
                    op_d  = cmd_op;
                    a_d   = cmd_a;
                    b_d   = cmd_b;
                    tag_d = cmd_tag;
`ifdef IMULDIV_DIV_CLIENT_ZERO_BYPASS_EN
                    if (cmd_b == 32'd0) begin
                        res_d   = cmd_op[1] ? cmd_a : 32'hFFFF_FFFF;
                        state_d = RESP;
                    end else begin
                        state_d = REQ;
                    end
`else
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                if (divreq_rdy) begin
                    lat_cnt_d = 8'd0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // the firing cycle itself counts toward the reported latency
                lat_cnt_d = lat_cnt_inc;
                if (divresp_val) begin
                    res_d   = op_q[1] ? divresp_msg_result[63:32] : divresp_msg_result[31:0];
                    lat_d   = lat_cnt_inc;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (res_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= 2'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            tag_q     <= '0;
            res_q     <= 32'd0;
            lat_cnt_q <= 8'd0;
            lat_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            res_q     <= res_d;
            lat_cnt_q <= lat_cnt_d;
            lat_q     <= lat_d;
        end
    end

    assign cmd_rdy       = (state_q == IDLE) && !reset;
    assign divreq_val    = (state_q == REQ);
    assign divresp_rdy   = (state_q == WAIT);
    assign res_val       = (state_q == RESP);
    assign divreq_msg_fn = op_q[0] ? `IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED : `IMULDIV_DIVREQ_MSG_FUNC_SIGNED;
    assign divreq_msg_a  = a_q;
    assign divreq_msg_b  = b_q;
    assign res_data      = res_q;
    assign res_tag       = tag_q;
    assign lat_cycles    = lat_q;

endmodule

// File: tb/tb_imuldiv_div_client.sv
// Self-checking bench for imuldiv_div_client: the bench plays execute stage, divider and result sink.
// Expectations follow IMULDIV_DIV_CLIENT_ZERO_BYPASS_EN when it is defined for the build.
`ifndef IMULDIV_DIVREQ_MSG_FUNC_SIGNED
`define IMULDIV_DIVREQ_MSG_FUNC_SIGNED 1'd0
`endif
`ifndef IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED
`define IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED 1'd1
`endif

module tb_imuldiv_div_client;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_val, cmd_rdy;
    logic [1:0]       cmd_op;
    logic [31:0]      cmd_a, cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic             divreq_msg_fn;
    logic [31:0]      divreq_msg_a, divreq_msg_b;
    logic             divreq_val, divreq_rdy;
    logic [63:0]      divresp_msg_result;
    logic             divresp_val, divresp_rdy;
    logic             res_val, res_rdy;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic [7:0]       lat_cycles;

    imuldiv_div_client #(.TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
        .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
        .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data), .res_tag(res_tag), .lat_cycles(lat_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic             chk_on;
    logic             exp_cmd_rdy, exp_divreq_val, exp_divresp_rdy, exp_res_val;
    logic             exp_fn;
    logic [31:0]      exp_a, exp_b, exp_res_data;
    logic [TAG_W-1:0] exp_res_tag;
    logic [7:0]       exp_lat;
    logic [31:0]      obs_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference divider: plain arithmetic, {remainder, quotient}.
    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmd_rdy", {31'd0, cmd_rdy}, {31'd0, exp_cmd_rdy});
            chk("divreq_val", {31'd0, divreq_val}, {31'd0, exp_divreq_val});
            chk("divresp_rdy", {31'd0, divresp_rdy}, {31'd0, exp_divresp_rdy});
            chk("res_val", {31'd0, res_val}, {31'd0, exp_res_val});
            chk("lat_cycles", {24'd0, lat_cycles}, {24'd0, exp_lat});
            if (exp_divreq_val) begin
                chk("divreq_msg_fn", {31'd0, divreq_msg_fn}, {31'd0, exp_fn});
                chk("divreq_msg_a", divreq_msg_a, exp_a);
                chk("divreq_msg_b", divreq_msg_b, exp_b);
            end
            if (exp_res_val) begin
                chk("res_data", res_data, exp_res_data);
                chk("res_tag", {28'd0, res_tag}, {28'd0, exp_res_tag});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic cr, input logic rqv, input logic rsr, input logic rv);
        exp_cmd_rdy     = cr;
        exp_divreq_val  = rqv;
        exp_divresp_rdy = rsr;
        exp_res_val     = rv;
    endtask

    task automatic junk_resp();
        divresp_val        = 1'($urandom_range(0, 1));
        divresp_msg_result = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_val = 1'b0;
            junk_resp();
            set_exp(1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input int req_stall, input int lat, input int res_stall);
        logic [63:0] full;
        logic [31:0] want;
        bit          byp;
        full = div_model(a, b, !op[0]);
        want = op[1] ? full[63:32] : full[31:0];
`ifdef IMULDIV_DIV_CLIENT_ZERO_BYPASS_EN
        byp = (b == 32'd0);
`else
        byp = 1'b0;
`endif
        cmd_val = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
        junk_resp();
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        cmd_val = 1'b0; cmd_op = 2'($urandom); cmd_a = $urandom; cmd_b = $urandom; cmd_tag = TAG_W'($urandom);
        if (!byp) begin
            exp_fn = op[0] ? `IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED : `IMULDIV_DIVREQ_MSG_FUNC_SIGNED;
            exp_a  = a;
            exp_b  = b;
            for (int i = 0; i <= req_stall; i++) begin
                divreq_rdy = (i == req_stall);
                junk_resp();
                set_exp(1'b0, 1'b1, 1'b0, 1'b0);
                step();
            end
            divreq_rdy = 1'b0;
            for (int i = 1; i <= lat; i++) begin
                divresp_val        = (i == lat);
                divresp_msg_result = (i == lat) ? full : {$urandom, $urandom};
                set_exp(1'b0, 1'b0, 1'b1, 1'b0);
                step();
            end
            exp_lat = (lat > 255) ? 8'd255 : 8'(lat);
        end
        exp_res_data = want;
        exp_res_tag  = tag;
        for (int i = 0; i <= res_stall; i++) begin
            res_rdy = (i == res_stall);
            junk_resp();
            set_exp(1'b0, 1'b0, 1'b0, 1'b1);
            obs_res = res_data;
            step();
        end
        res_rdy = 1'b0;
        divresp_val = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        chk_on = 1'b0;
        reset = 1'b1; cmd_val = 1'b0; cmd_op = 2'd0; cmd_a = 32'd0; cmd_b = 32'd0; cmd_tag = '0;
        divreq_rdy = 1'b0; divresp_val = 1'b0; divresp_msg_result = 64'd0; res_rdy = 1'b0;
        exp_lat = 8'd0; exp_fn = 1'b0; exp_a = 32'd0; exp_b = 32'd0; exp_res_data = 32'd0; exp_res_tag = '0;
        obs_res = 32'd0;
        step();
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        chk_on = 1'b1;
        step();
        step();
        reset = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset res_data", res_data, 32'd0);
        chk("reset res_tag", {28'd0, res_tag}, 32'd0);
        chk("reset divreq_msg_a", divreq_msg_a, 32'd0);
        chk("reset divreq_msg_b", divreq_msg_b, 32'd0);
        chk("reset divreq_msg_fn", {31'd0, divreq_msg_fn}, 32'd0);
        idle(1);

        txn(2'd1, 32'd100, 32'd7, 4'h5, 0, 33, 0);
        chk("divu 100/7", obs_res, 32'd14);
        idle(2);
        txn(2'd2, 32'hFFFF_FFF9, 32'd2, 4'hA, 5, 4, 0);
        chk("rem -7/2", obs_res, 32'hFFFF_FFFF);
        txn(2'd0, 32'hFFFF_FFEC, 32'd3, 4'h3, 0, 6, 10);
        chk("div -20/3", obs_res, 32'hFFFF_FFFA);
        txn(2'd3, 32'h0000_1234, 32'd0, 4'h9, 1, 5, 1);
        chk("remu b=0", obs_res, 32'h0000_1234);
        txn(2'd0, 32'd77, 32'd0, 4'h1, 0, 3, 0);
        chk("div b=0", obs_res, 32'hFFFF_FFFF);

        // reset during WAIT drops the command
        cmd_val = 1'b1; cmd_op = 2'd1; cmd_a = 32'd50; cmd_b = 32'd5; cmd_tag = 4'h7;
        divresp_val = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        cmd_val = 1'b0;
        exp_fn = `IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED; exp_a = 32'd50; exp_b = 32'd5;
        divreq_rdy = 1'b1;
        set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        divreq_rdy = 1'b0;
        set_exp(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        chk_on = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_lat = 8'd0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        chk_on = 1'b1;
        idle(1);
        txn(2'd1, 32'd9, 32'd3, 4'h2, 0, 2, 0);
        chk("divu 9/3 after reset", obs_res, 32'd3);

        txn(2'd1, 32'd1000, 32'd10, 4'hE, 2, 300, 0);
        chk("divu stalled", obs_res, 32'd100);
        chk("lat saturated", {24'd0, lat_cycles}, 32'd255);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = -32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            txn(2'($urandom_range(0, 3)), ra, rb, TAG_W'($urandom), $urandom_range(0, 4),
                $urandom_range(1, 40), $urandom_range(0, 4));
            idle($urandom_range(0, 2));
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
